sh_intc_arb: RTL and testbench

Parametrised interrupt arbiter for the SH CPU core: collects NUM_SRC on-chip peripheral requests (each with 4-bit IPR priority and 7-bit vector), the external IRL level pins and the NMI pin. It selects the highest-priority pending request and presents it to the CPU as an `IntReq_t`. It then completes the CPU's `IntAck_t` handshake by pulsing a per-source clear back to the winning peripheral. It sits between the peripheral blocks (DIVU, DMAC, WDT, SCI, FRT, …) and the CPU exception unit, replacing the fixed-source INTC.

---
 rtl/sh_intc_arb.sv | 197 +++++++++++++++++++
 tb/tb_sh_intc_arb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sh_intc_arb.sv
// Interrupt arbiter for the SH core: picks the highest-priority pending NMI, IRL or
// on-chip request, presents it to the CPU, and completes the acknowledge handshake.
module sh_intc_arb #(
  parameter int NUM_SRC = 8,
  parameter int VEC_W   = 7
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CE_R,
  input  logic [NUM_SRC-1:0]       SRC_REQ,
  input  logic [4*NUM_SRC-1:0]     SRC_IP,
  input  logic [VEC_W*NUM_SRC-1:0] SRC_VEC,
  input  logic [3:0]               IRL_N,
  input  logic [7:0]               EXT_VEC,
  input  logic                     VECMD,
  input  logic                     NMI_N,
  input  logic                     NMIE,
  output logic [13:0]              INT_REQ,   // {LVL[3:0], VEC[7:0], RES, REQ}
  input  logic [4:0]               INT_ACK,   // {LVL[3:0], ACK}
  output logic [NUM_SRC-1:0]       SRC_CLR,
  output logic                     NMIL
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_CLR} state_t;
  typedef enum logic [1:0] {K_ONCHIP, K_IRL, K_NMI} kind_t;

  state_t             state_q, state_d;
  kind_t              kind_q, kind_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         lvl_q, lvl_d;
  logic [7:0]         vec_q, vec_d;
  logic               req_q, req_d;
  logic [NUM_SRC-1:0] srcclr_q, srcclr_d;
  logic               sync1_q, sync2_q, prev_q;
  logic               nmi_pend_q, nmi_pend_d;

  logic               nmi_edge, nmi_act, nmi_clr;
  logic               oc_valid;
  logic [3:0]         oc_lvl;
  logic [7:0]         oc_vec;
  logic [IDX_W-1:0]   oc_idx;
  logic [3:0]         irl_lvl;
  logic [7:0]         irl_vec;
  logic               cand_valid;
  kind_t              cand_kind;
  logic [3:0]         cand_lvl;
  logic [7:0]         cand_vec;
  logic [IDX_W-1:0]   cand_idx;
  logic [4:0]         cand_rank, lat_rank;
  logic               lat_active;
  logic               unused_ack_lvl;

  assign unused_ack_lvl = ^INT_ACK[4:1];

  assign nmi_edge = NMIE ? (~prev_q & sync2_q) : (prev_q & ~sync2_q);
  assign nmi_clr  = (state_q == ST_CLR) && (kind_q == K_NMI);
  // While clearing an NMI only a fresh edge may re-arbitrate it from CLR.
  assign nmi_act    = nmi_clr ? nmi_edge : nmi_pend_q;
  assign nmi_pend_d = nmi_edge | (nmi_pend_q & ~nmi_clr);

  always_comb begin
    oc_valid = 1'b0;
    oc_lvl   = '0;
    oc_vec   = '0;
    oc_idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (SRC_REQ[i] && (SRC_IP[4*i +: 4] != 4'd0) &&
          (!oc_valid || (SRC_IP[4*i +: 4] > oc_lvl))) begin
        oc_valid = 1'b1;
        oc_lvl   = SRC_IP[4*i +: 4];
        oc_vec   = 8'(SRC_VEC[VEC_W*i +: VEC_W]);
        oc_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    irl_lvl    = ~IRL_N;
    irl_vec    = VECMD ? EXT_VEC : (8'd64 + {5'd0, irl_lvl[3:1]});
    cand_valid = 1'b0;
    cand_kind  = K_ONCHIP;
    cand_lvl   = '0;
    cand_vec   = '0;
    cand_idx   = '0;
    if (nmi_act) begin
      cand_valid = 1'b1;
      cand_kind  = K_NMI;
      cand_lvl   = 4'hF;
      cand_vec   = 8'd11;
    end else if ((irl_lvl != 4'd0) && (irl_lvl >= oc_lvl)) begin
      cand_valid = 1'b1;
      cand_kind  = K_IRL;
      cand_lvl   = irl_lvl;
      cand_vec   = irl_vec;
    end else if (oc_valid) begin
      cand_valid = 1'b1;
      cand_lvl   = oc_lvl;
      cand_vec   = oc_vec;
      cand_idx   = oc_idx;
    end
    cand_rank = (cand_kind == K_NMI) ? 5'd16 : {1'b0, cand_lvl};
    lat_rank  = (kind_q == K_NMI) ? 5'd16 : {1'b0, lvl_q};
  end

  always_comb begin
    case (kind_q)
      K_NMI:   lat_active = nmi_pend_q;
      K_IRL:   lat_active = (irl_lvl != 4'd0);
      default: lat_active = SRC_REQ[idx_q] && (SRC_IP[4*int'(idx_q) +: 4] != 4'd0);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    idx_d    = idx_q;
    lvl_d    = lvl_q;
    vec_d    = vec_q;
    req_d    = req_q;
    srcclr_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (cand_valid) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          kind_d  = cand_kind;
          idx_d   = cand_idx;
          lvl_d   = cand_lvl;
          vec_d   = cand_vec;
        end
      end
      ST_REQ: begin
        if (INT_ACK[0]) begin
          state_d = ST_CLR;
          req_d   = 1'b0;
          if (kind_q == K_ONCHIP) srcclr_d[idx_q] = 1'b1;
        end else if ((!lat_active || (cand_rank > lat_rank)) && cand_valid) begin
          kind_d = cand_kind;
          idx_d  = cand_idx;
          lvl_d  = cand_lvl;
          vec_d  = cand_vec;
        end else if (!lat_active) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        // Re-arbitrating here keeps back-to-back requests to a single idle cycle.
        if (cand_valid) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          kind_d  = cand_kind;
          idx_d   = cand_idx;
          lvl_d   = cand_lvl;
          vec_d   = cand_vec;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      kind_q     <= K_ONCHIP;
      idx_q      <= '0;
      lvl_q      <= 4'hF;
      vec_q      <= '0;
      req_q      <= 1'b0;
      srcclr_q   <= '0;
      sync1_q    <= NMI_N;
      sync2_q    <= NMI_N;
      prev_q     <= NMI_N;
      nmi_pend_q <= 1'b0;
    end else if (CE_R) begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      idx_q      <= idx_d;
      lvl_q      <= lvl_d;
      vec_q      <= vec_d;
      req_q      <= req_d;
      srcclr_q   <= srcclr_d;
      sync1_q    <= NMI_N;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  assign INT_REQ = {lvl_q, vec_q, 1'b0, req_q};
  assign SRC_CLR = srcclr_q;
  assign NMIL    = sync2_q;

endmodule

// File: tb/tb_sh_intc_arb.sv
// Directed bench for sh_intc_arb: arbitration, handshake, preemption, NMI and clock enable.
module tb_sh_intc_arb;

  logic        CLK = 1'b0;
  logic        RST, CE_R;
  logic [7:0]  SRC_REQ;
  logic [31:0] SRC_IP;
  logic [55:0] SRC_VEC;
  logic [3:0]  IRL_N;
  logic [7:0]  EXT_VEC;
  logic        VECMD, NMI_N, NMIE;
  logic [13:0] INT_REQ;
  logic [4:0]  INT_ACK;
  logic [7:0]  SRC_CLR;
  logic        NMIL;

  int tests = 0;
  int fails = 0;

  sh_intc_arb #(.NUM_SRC(8), .VEC_W(7)) dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .SRC_REQ(SRC_REQ), .SRC_IP(SRC_IP),
    .SRC_VEC(SRC_VEC), .IRL_N(IRL_N), .EXT_VEC(EXT_VEC), .VECMD(VECMD),
    .NMI_N(NMI_N), .NMIE(NMIE), .INT_REQ(INT_REQ), .INT_ACK(INT_ACK),
    .SRC_CLR(SRC_CLR), .NMIL(NMIL)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic r, input logic [3:0] ip, input logic [6:0] v);
    SRC_REQ[i]       = r;
    SRC_IP[4*i +: 4] = ip;
    SRC_VEC[7*i +: 7] = v;
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [3:0] lvl, input logic [7:0] vec);
    chk({tag, "_req"}, 32'(INT_REQ[0]), 32'(req));
    chk({tag, "_lvl"}, 32'(INT_REQ[13:10]), 32'(lvl));
    chk({tag, "_vec"}, 32'(INT_REQ[9:2]), 32'(vec));
  endtask

  initial begin
    RST = 1'b1; CE_R = 1'b1; SRC_REQ = '0; SRC_IP = '0; SRC_VEC = '0;
    IRL_N = 4'hF; EXT_VEC = 8'h99; VECMD = 1'b0; NMI_N = 1'b1; NMIE = 1'b1;
    INT_ACK = '0;
    step(3);
    RST = 1'b0;
    chk("rst_intreq", 32'(INT_REQ), 32'h3C00);
    chk("rst_srcclr", 32'(SRC_CLR), 32'h0);
    chk("rst_nmil", 32'(NMIL), 32'h1);
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("rst_no_nmi", 32'(INT_REQ[0]), 32'h0);
    end

    // Equal-priority on-chip sources: lowest index wins.
    set_src(2, 1'b1, 4'd5, 7'h60);
    set_src(1, 1'b1, 4'd5, 7'h50);
    step(1);
    chk_req("arb_oc", 1'b1, 4'd5, 8'h50);
    // Ack (with unrelated ACK.LVL); IRL level 5 appears and wins the tie from CLR.
    INT_ACK = {4'h3, 1'b1};
    IRL_N = 4'b1010;
    step(1);
    chk("arb_ack_req", 32'(INT_REQ[0]), 32'h0);
    chk("arb_ack_clr", 32'(SRC_CLR), 32'h02);
    INT_ACK = '0;
    step(1);
    chk_req("arb_irl", 1'b1, 4'd5, 8'h42);
    chk("arb_irl_clr", 32'(SRC_CLR), 32'h0);
    IRL_N = 4'hF;
    set_src(1, 1'b0, 4'd0, 7'h0);
    set_src(2, 1'b0, 4'd0, 7'h0);
    step(1);
    chk("arb_drop_req", 32'(INT_REQ[0]), 32'h0);

    // Handshake with back-to-back reassertion.
    set_src(3, 1'b1, 4'd9, 7'h70);
    step(1);
    chk_req("hs_req", 1'b1, 4'd9, 8'h70);
    INT_ACK = 5'b1;
    step(1);
    INT_ACK = '0;
    chk("hs_n1_req", 32'(INT_REQ[0]), 32'h0);
    chk("hs_n1_clr", 32'(SRC_CLR), 32'h08);
    step(1);
    chk("hs_n2_req", 32'(INT_REQ[0]), 32'h1);
    chk("hs_n2_clr", 32'(SRC_CLR), 32'h0);
    set_src(3, 1'b0, 4'd0, 7'h0);
    step(1);
    chk("hs_drop_req", 32'(INT_REQ[0]), 32'h0);
    chk("hs_drop_clr", 32'(SRC_CLR), 32'h0);

    // Preemption then withdrawal.
    set_src(0, 1'b1, 4'd3, 7'h11);
    step(1);
    chk_req("pre_lo", 1'b1, 4'd3, 8'h11);
    set_src(4, 1'b1, 4'd12, 7'h44);
    step(1);
    chk_req("pre_hi", 1'b1, 4'hC, 8'h44);
    set_src(0, 1'b0, 4'd0, 7'h0);
    set_src(4, 1'b0, 4'd0, 7'h0);
    step(1);
    chk("wd_req", 32'(INT_REQ[0]), 32'h0);
    chk("wd_clr", 32'(SRC_CLR), 32'h0);
    step(1);
    chk("wd_clr2", 32'(SRC_CLR), 32'h0);

    // NMI, falling edge select.
    NMIE = 1'b0;
    NMI_N = 1'b0;
    step(3);
    chk("nmi_q3_req", 32'(INT_REQ[0]), 32'h0);
    step(1);
    chk_req("nmi_q4", 1'b1, 4'hF, 8'h0B);
    chk("nmi_nmil", 32'(NMIL), 32'h0);
    INT_ACK = 5'b1;
    step(1);
    INT_ACK = '0;
    chk("nmi_clr_req", 32'(INT_REQ[0]), 32'h0);
    chk("nmi_clr_srcclr", 32'(SRC_CLR), 32'h0);
    step(1);
    chk("nmi_cleared1", 32'(INT_REQ[0]), 32'h0);
    step(1);
    chk("nmi_cleared2", 32'(INT_REQ[0]), 32'h0);

    // Re-arm NMI; second falling edge lands in the CLR cycle.
    NMI_N = 1'b1;
    step(4);
    NMI_N = 1'b0;
    step(4);
    chk_req("nmi2_req", 1'b1, 4'hF, 8'h0B);
    NMI_N = 1'b1;
    step(2);
    NMI_N = 1'b0;
    step(1);
    chk("nmi2_hold", 32'(INT_REQ[0]), 32'h1);
    INT_ACK = 5'b1;
    step(1);
    INT_ACK = '0;
    chk("nmi2_clr_req", 32'(INT_REQ[0]), 32'h0);
    step(1);
    chk_req("nmi2_rereq", 1'b1, 4'hF, 8'h0B);
    INT_ACK = 5'b1;
    step(1);
    INT_ACK = '0;
    step(1);
    chk("nmi2_done", 32'(INT_REQ[0]), 32'h0);

    // Clock-enable gating across an ACK.
    set_src(5, 1'b1, 4'd7, 7'h25);
    step(1);
    chk_req("ce_req", 1'b1, 4'd7, 8'h25);
    CE_R = 1'b0;
    INT_ACK = 5'b1;
    step(3);
    chk("ce_hold_req", 32'(INT_REQ[0]), 32'h1);
    chk("ce_hold_clr", 32'(SRC_CLR), 32'h0);
    CE_R = 1'b1;
    step(1);
    chk("ce_ack_req", 32'(INT_REQ[0]), 32'h0);
    chk("ce_ack_clr", 32'(SRC_CLR), 32'h20);
    INT_ACK = '0;
    CE_R = 1'b0;
    step(2);
    chk("ce_clr_held", 32'(SRC_CLR), 32'h20);
    CE_R = 1'b1;
    set_src(5, 1'b0, 4'd0, 7'h0);
    step(1);
    chk("ce_done_clr", 32'(SRC_CLR), 32'h0);
    chk("ce_done_req", 32'(INT_REQ[0]), 32'h0);

    // Reset in the middle of a handshake: no clear pulse.
    set_src(6, 1'b1, 4'd2, 7'h33);
    step(1);
    chk_req("mrst_req", 1'b1, 4'd2, 8'h33);
    INT_ACK = 5'b1;
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    INT_ACK = '0;
    set_src(6, 1'b0, 4'd0, 7'h0);
    chk("mrst_intreq", 32'(INT_REQ), 32'h3C00);
    chk("mrst_clr", 32'(SRC_CLR), 32'h0);
    step(1);
    chk("mrst_clr2", 32'(SRC_CLR), 32'h0);
    chk("mrst_req2", 32'(INT_REQ[0]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
